obj_locator: RTL and testbench

OBJ_LOCATOR -- requirements
Module: obj_locator

---
 rtl/obj_locator_if.sv | 58 +++++
 rtl/obj_locator.sv | 190 +++++++++++++++++++
 tb/tb_obj_locator.sv | 397 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/obj_locator_if.sv
// ----------------------------------------------------------------------------
// obj_locator_if
//   Bundles the pixel query, position-write and result signals of the object
//   locator.
//
//   modport master : drives pixels, frame pulses and position writes; observes
//                    results (the video pipeline / testbench side).
//   modport slave  : the locator itself.
//
//   Signals
//     pix_valid, pix_x, pix_y          pixel under test and its qualifier
//     frame_start                      one-cycle frame boundary pulse
//     pos_wr_en, pos_wr_idx,
//     pos_wr_x, pos_wr_y               shadow position write port
//     out_valid, hit, hit_idx,
//     obj_x, obj_y, hit_mask           per-pixel result (2-cycle latency)
//     collision, coll_mask             sticky per-frame overlap flags
//     frame_collision                  collision value at the last frame_start
// ----------------------------------------------------------------------------
interface obj_locator_if #(
    parameter int NUM_OBJ   = 4,
    parameter int SIZE_LOG2 = 5,
    parameter int COORD_W   = 10,
    parameter int IDX_W     = 2
);
    logic                 pix_valid;
    logic [COORD_W-1:0]   pix_x;
    logic [COORD_W-1:0]   pix_y;
    logic                 frame_start;
    logic                 pos_wr_en;
    logic [IDX_W-1:0]     pos_wr_idx;
    logic [COORD_W-1:0]   pos_wr_x;
    logic [COORD_W-1:0]   pos_wr_y;

    logic                 out_valid;
    logic                 hit;
    logic [IDX_W-1:0]     hit_idx;
    logic [SIZE_LOG2-1:0] obj_x;
    logic [SIZE_LOG2-1:0] obj_y;
    logic [NUM_OBJ-1:0]   hit_mask;
    logic                 collision;
    logic [NUM_OBJ-1:0]   coll_mask;
    logic                 frame_collision;

    modport master (
        output pix_valid, pix_x, pix_y, frame_start,
        output pos_wr_en, pos_wr_idx, pos_wr_x, pos_wr_y,
        input  out_valid, hit, hit_idx, obj_x, obj_y, hit_mask,
        input  collision, coll_mask, frame_collision
    );

    modport slave (
        input  pix_valid, pix_x, pix_y, frame_start,
        input  pos_wr_en, pos_wr_idx, pos_wr_x, pos_wr_y,
        output out_valid, hit, hit_idx, obj_x, obj_y, hit_mask,
        output collision, coll_mask, frame_collision
    );
endinterface

// File: rtl/obj_locator.sv
// ----------------------------------------------------------------------------
// obj_locator
//   Tests each incoming screen pixel against NUM_OBJ square objects of edge
//   2^SIZE_LOG2 and reports which objects cover it, the lowest-index winner
//   and the pixel offset inside that winner. Object positions are double
//   buffered (shadow/active) so software can move objects mid-frame without
//   tearing; active positions change only at frame_start. Overlaps between
//   objects are accumulated per frame into sticky collision flags.
//
//   Ports
//     clk    single clock, rising edge
//     rst_n  asynchronous active-low reset
//     bus    obj_locator_if.slave (pixel in, position writes, results out)
//
//   Pipeline: stage 1 registers per-object cover bits and offsets, stage 2
//   registers the priority-selected result and collision state.
// ----------------------------------------------------------------------------
module obj_locator #(
    parameter int NUM_OBJ   = 4,
    parameter int SIZE_LOG2 = 5,
    parameter int COORD_W   = 10,
    parameter int IDX_W     = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    obj_locator_if.slave bus
);

    // Object edge length in COORD_W+1 bits so pos + edge never wraps: an
    // object near the right/bottom screen edge must not reappear at 0.
    localparam logic [COORD_W:0] OBJ_EDGE = (COORD_W + 1)'(1) << SIZE_LOG2;

    typedef logic [NUM_OBJ-1:0][COORD_W-1:0]   pos_arr_t;
    typedef logic [NUM_OBJ-1:0][SIZE_LOG2-1:0] off_arr_t;

    // Position registers
    pos_arr_t shadow_x_q, shadow_x_d;
    pos_arr_t shadow_y_q, shadow_y_d;
    pos_arr_t active_x_q, active_x_d;
    pos_arr_t active_y_q, active_y_d;

    // Stage 1
    logic               s1_valid_q, s1_valid_d;
    logic [NUM_OBJ-1:0] s1_cover_q, s1_cover_d;
    off_arr_t           s1_off_x_q, s1_off_x_d;
    off_arr_t           s1_off_y_q, s1_off_y_d;

    // Stage 2 / outputs
    logic                 out_valid_q, out_valid_d;
    logic                 hit_q, hit_d;
    logic [IDX_W-1:0]     hit_idx_q, hit_idx_d;
    logic [SIZE_LOG2-1:0] obj_x_q, obj_x_d;
    logic [SIZE_LOG2-1:0] obj_y_q, obj_y_d;
    logic [NUM_OBJ-1:0]   hit_mask_q, hit_mask_d;
    logic                 collision_q, collision_d;
    logic [NUM_OBJ-1:0]   coll_mask_q, coll_mask_d;
    logic                 frame_coll_q, frame_coll_d;

    logic [NUM_OBJ-1:0]   valid_cover;
    logic                 overlap;

    // ------------------------------------------------------------------------
    // Shadow / active positions. The shadow next-state feeds the active copy
    // so a write coinciding with frame_start is visible in the same edge.
    // ------------------------------------------------------------------------
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned (which would infer a latch).
        shadow_x_d = shadow_x_q;
        shadow_y_d = shadow_y_q;
        if (bus.pos_wr_en && (int'(bus.pos_wr_idx) < NUM_OBJ)) begin
            shadow_x_d[bus.pos_wr_idx] = bus.pos_wr_x;
            shadow_y_d[bus.pos_wr_idx] = bus.pos_wr_y;
        end
        active_x_d = bus.frame_start ? shadow_x_d : active_x_q;
        active_y_d = bus.frame_start ? shadow_y_d : active_y_q;
    end

    // ------------------------------------------------------------------------
    // Stage 1: per-object cover test against the active positions held now.
    // Offsets are taken modulo the object size; they are only meaningful
    // where the cover bit is set.
    // ------------------------------------------------------------------------
    always_comb begin
        s1_valid_d = bus.pix_valid;
        s1_cover_d = '0;
        s1_off_x_d = '0;
        s1_off_y_d = '0;
        for (int i = 0; i < NUM_OBJ; i++) begin
            s1_cover_d[i] = (bus.pix_x >= active_x_q[i])
                         && ({1'b0, bus.pix_x} < ({1'b0, active_x_q[i]} + OBJ_EDGE))
                         && (bus.pix_y >= active_y_q[i])
                         && ({1'b0, bus.pix_y} < ({1'b0, active_y_q[i]} + OBJ_EDGE));
            s1_off_x_d[i] = SIZE_LOG2'(bus.pix_x - active_x_q[i]);
            s1_off_y_d[i] = SIZE_LOG2'(bus.pix_y - active_y_q[i]);
        end
    end

    // ------------------------------------------------------------------------
    // Stage 2: lowest-index priority select and per-frame collision tracking.
    // ------------------------------------------------------------------------
    always_comb begin
        valid_cover = s1_valid_q ? s1_cover_q : '0;
        out_valid_d = s1_valid_q;
        hit_d       = |valid_cover;
        hit_mask_d  = valid_cover;
        hit_idx_d   = '0;
        obj_x_d     = '0;
        obj_y_d     = '0;
        // Walk downwards so the lowest set index is the last one written.
        for (int i = NUM_OBJ - 1; i >= 0; i--) begin
            if (valid_cover[i]) begin
                hit_idx_d = IDX_W'(i);
                obj_x_d   = s1_off_x_q[i];
                obj_y_d   = s1_off_y_q[i];
            end
        end

        // Two or more bits set: clearing the lowest set bit leaves something.
        overlap = (valid_cover & (valid_cover - NUM_OBJ'(1))) != '0;

        if (bus.frame_start) begin
            frame_coll_d = collision_q | overlap;
            collision_d  = overlap;
            coll_mask_d  = overlap ? valid_cover : '0;
        end else begin
            frame_coll_d = frame_coll_q;
            collision_d  = collision_q | overlap;
            coll_mask_d  = coll_mask_q | (overlap ? valid_cover : '0);
        end
    end

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the position arrays are small register banks, not RAM, so
            // they take the async reset like any other flop.
            shadow_x_q   <= '0;
            shadow_y_q   <= '0;
            active_x_q   <= '0;
            active_y_q   <= '0;
            s1_valid_q   <= 1'b0;
            s1_cover_q   <= '0;
            s1_off_x_q   <= '0;
            s1_off_y_q   <= '0;
            out_valid_q  <= 1'b0;
            hit_q        <= 1'b0;
            hit_idx_q    <= '0;
            obj_x_q      <= '0;
            obj_y_q      <= '0;
            hit_mask_q   <= '0;
            collision_q  <= 1'b0;
            coll_mask_q  <= '0;
            frame_coll_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the values
            // from before this edge, independent of statement order.
            shadow_x_q   <= shadow_x_d;
            shadow_y_q   <= shadow_y_d;
            active_x_q   <= active_x_d;
            active_y_q   <= active_y_d;
            s1_valid_q   <= s1_valid_d;
            s1_cover_q   <= s1_cover_d;
            s1_off_x_q   <= s1_off_x_d;
            s1_off_y_q   <= s1_off_y_d;
            out_valid_q  <= out_valid_d;
            hit_q        <= hit_d;
            hit_idx_q    <= hit_idx_d;
            obj_x_q      <= obj_x_d;
            obj_y_q      <= obj_y_d;
            hit_mask_q   <= hit_mask_d;
            collision_q  <= collision_d;
            coll_mask_q  <= coll_mask_d;
            frame_coll_q <= frame_coll_d;
        end
    end

    assign bus.out_valid       = out_valid_q;
    assign bus.hit             = hit_q;
    assign bus.hit_idx         = hit_idx_q;
    assign bus.obj_x           = obj_x_q;
    assign bus.obj_y           = obj_y_q;
    assign bus.hit_mask        = hit_mask_q;
    assign bus.collision       = collision_q;
    assign bus.coll_mask       = coll_mask_q;
    assign bus.frame_collision = frame_coll_q;

endmodule

// File: tb/tb_obj_locator.sv
// ----------------------------------------------------------------------------
// tb_obj_locator
//   Self-checking bench for obj_locator at default parameters. A behavioural
//   model keeps shadow/active positions as plain integers, evaluates each
//   pixel with integer range tests and delays the result by the pipeline
//   latency. Directed scenarios also check hand-derived constants.
// ----------------------------------------------------------------------------
module tb_obj_locator;

    localparam int NUM_OBJ   = 4;
    localparam int SIZE_LOG2 = 5;
    localparam int COORD_W   = 10;
    localparam int IDX_W     = 2;
    localparam int EDGE      = 1 << SIZE_LOG2;
    localparam int CMASK     = (1 << COORD_W) - 1;

    typedef struct packed {
        logic                 valid;
        logic                 hit;
        logic [IDX_W-1:0]     idx;
        logic [SIZE_LOG2-1:0] ox;
        logic [SIZE_LOG2-1:0] oy;
        logic [NUM_OBJ-1:0]   mask;
        logic                 coll;
        logic [NUM_OBJ-1:0]   cmask;
        logic                 fcoll;
    } res_t;

    logic clk = 1'b0;
    logic rst_n;

    obj_locator_if #(.NUM_OBJ(NUM_OBJ), .SIZE_LOG2(SIZE_LOG2),
                     .COORD_W(COORD_W), .IDX_W(IDX_W)) bus ();

    obj_locator #(.NUM_OBJ(NUM_OBJ), .SIZE_LOG2(SIZE_LOG2),
                  .COORD_W(COORD_W), .IDX_W(IDX_W)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int compares = 0;
    int fails    = 0;

    // Model state
    int   m_sx[NUM_OBJ];
    int   m_sy[NUM_OBJ];
    int   m_ax[NUM_OBJ];
    int   m_ay[NUM_OBJ];
    res_t pend;
    bit   m_coll;
    bit   m_fcoll;
    logic [NUM_OBJ-1:0] m_cmask;
    res_t exp_res;

    function automatic res_t dut_res();
        res_t r;
        r.valid = bus.out_valid;
        r.hit   = bus.hit;
        r.idx   = bus.hit_idx;
        r.ox    = bus.obj_x;
        r.oy    = bus.obj_y;
        r.mask  = bus.hit_mask;
        r.coll  = bus.collision;
        r.cmask = bus.coll_mask;
        r.fcoll = bus.frame_collision;
        return r;
    endfunction

    function automatic string fmt(input res_t r);
        return $sformatf("v=%0b hit=%0b idx=%0d ox=%0d oy=%0d mask=%b coll=%0b cmask=%b fcoll=%0b",
                         r.valid, r.hit, r.idx, r.ox, r.oy, r.mask, r.coll, r.cmask, r.fcoll);
    endfunction

    // Reference evaluation of one pixel against the model's active positions.
    function automatic res_t eval(input bit pv, input int px, input int py);
        res_t r = '0;
        if (!pv) return r;
        r.valid = 1'b1;
        for (int i = 0; i < NUM_OBJ; i++) begin
            if (px >= m_ax[i] && px < m_ax[i] + EDGE &&
                py >= m_ay[i] && py < m_ay[i] + EDGE) begin
                r.mask[i] = 1'b1;
                if (!r.hit) begin
                    r.hit = 1'b1;
                    r.idx = IDX_W'(i);
                    r.ox  = SIZE_LOG2'(px - m_ax[i]);
                    r.oy  = SIZE_LOG2'(py - m_ay[i]);
                end
            end
        end
        return r;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < NUM_OBJ; i++) begin
            m_sx[i] = 0; m_sy[i] = 0; m_ax[i] = 0; m_ay[i] = 0;
        end
        pend    = '0;
        m_coll  = 1'b0;
        m_fcoll = 1'b0;
        m_cmask = '0;
        exp_res = '0;
    endfunction

    // Drive one cycle of inputs, advance one clock edge and update the model.
    // On return (#1 after the edge) exp_res holds the expected DUT outputs.
    task automatic step(input bit pv, input int px, input int py, input bit fs,
                        input bit we, input int wi, input int wx, input int wy);
        bit ovl;
        px &= CMASK; py &= CMASK; wx &= CMASK; wy &= CMASK;
        bus.pix_valid   = pv;
        bus.pix_x       = COORD_W'(px);
        bus.pix_y       = COORD_W'(py);
        bus.frame_start = fs;
        bus.pos_wr_en   = we;
        bus.pos_wr_idx  = IDX_W'(wi);
        bus.pos_wr_x    = COORD_W'(wx);
        bus.pos_wr_y    = COORD_W'(wy);
        @(posedge clk);
        ovl = pend.valid && ($countones(pend.mask) >= 2);
        if (fs) begin
            m_fcoll = m_coll || ovl;
            m_coll  = ovl;
            m_cmask = ovl ? pend.mask : '0;
        end else begin
            m_coll = m_coll || ovl;
            if (ovl) m_cmask |= pend.mask;
        end
        exp_res       = pend;
        exp_res.coll  = m_coll;
        exp_res.cmask = m_cmask;
        exp_res.fcoll = m_fcoll;
        pend = eval(pv, px, py);
        if (we && wi < NUM_OBJ) begin
            m_sx[wi] = wx;
            m_sy[wi] = wy;
        end
        if (fs) begin
            m_ax = m_sx;
            m_ay = m_sy;
        end
        #1;
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic place(input int idx, input int x, input int y);
        step(0, 0, 0, 0, 1, idx, x, y);
    endtask

    task automatic pixel(input int x, input int y);
        step(1, x, y, 0, 0, 0, 0, 0);
    endtask

    task automatic frame();
        step(0, 0, 0, 1, 0, 0, 0, 0);
    endtask

    // ------------------------------------------------------------------------
    task automatic test_reset();
        rst_n = 1'b1;
        step(0, 0, 0, 0, 0, 0, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        compares++;
        if (dut_res() !== res_t'(0)) begin
            fails++;
            $display("FAIL reset_outputs: got %s want all zero", fmt(dut_res()));
        end
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        model_reset();
        // All positions reset to (0,0): pixel (31,0) is covered by every object.
        pixel(31, 0);
        idle();
        compares++;
        if (dut_res() !== exp_res || bus.hit_mask !== 4'b1111 || bus.obj_x !== 5'd31) begin
            fails++;
            $display("FAIL reset_positions: got %s want %s", fmt(dut_res()), fmt(exp_res));
        end
    endtask

    task automatic test_hit_offsets();
        place(0, 600, 600);
        place(1, 100, 50);
        place(2, 700, 700);
        place(3, 800, 800);
        frame();
        pixel(131, 81);
        pixel(132, 81);
        compares++;
        if (dut_res() !== exp_res || bus.hit !== 1'b1 || bus.hit_idx !== 2'd1 ||
            bus.obj_x !== 5'd31 || bus.obj_y !== 5'd31) begin
            fails++;
            $display("FAIL far_corner_hit: got %s want %s", fmt(dut_res()), fmt(exp_res));
        end
        idle();
        compares++;
        if (dut_res() !== exp_res || bus.out_valid !== 1'b1 || bus.hit !== 1'b0 ||
            bus.hit_idx !== 2'd0 || bus.obj_x !== 5'd0 || bus.obj_y !== 5'd0 ||
            bus.hit_mask !== 4'd0) begin
            fails++;
            $display("FAIL just_outside_miss: got %s want %s", fmt(dut_res()), fmt(exp_res));
        end
    endtask

    task automatic test_overlap();
        place(0, 10, 10);
        place(2, 20, 20);
        frame();
        pixel(25, 25);
        idle();
        compares++;
        if (dut_res() !== exp_res || bus.hit_idx !== 2'd0 || bus.obj_x !== 5'd15 ||
            bus.obj_y !== 5'd15 || bus.hit_mask !== 4'b0101 || bus.collision !== 1'b1 ||
            bus.coll_mask !== 4'b0101) begin
            fails++;
            $display("FAIL overlap_pixel: got %s want %s", fmt(dut_res()), fmt(exp_res));
        end
        frame();
        compares++;
        if (dut_res() !== exp_res || bus.frame_collision !== 1'b1 ||
            bus.collision !== 1'b0 || bus.coll_mask !== 4'd0) begin
            fails++;
            $display("FAIL overlap_frame_capture: got %s want %s", fmt(dut_res()), fmt(exp_res));
        end
        frame();
        compares++;
        if (dut_res() !== exp_res || bus.frame_collision !== 1'b0) begin
            fails++;
            $display("FAIL overlap_quiet_frame: got %s want %s", fmt(dut_res()), fmt(exp_res));
        end
    endtask

    task automatic test_screen_edge();
        place(3, 1016, 0);
        frame();
        pixel(1023, 5);
        pixel(4, 5);
        compares++;
        if (dut_res() !== exp_res || bus.hit !== 1'b1 || bus.hit_idx !== 2'd3 ||
            bus.obj_x !== 5'd7 || bus.obj_y !== 5'd5) begin
            fails++;
            $display("FAIL edge_hit: got %s want %s", fmt(dut_res()), fmt(exp_res));
        end
        idle();
        compares++;
        if (dut_res() !== exp_res || bus.out_valid !== 1'b1 || bus.hit !== 1'b0) begin
            fails++;
            $display("FAIL edge_no_wrap: got %s want %s", fmt(dut_res()), fmt(exp_res));
        end
    endtask

    task automatic test_shadow();
        place(0, 200, 200);
        pixel(205, 205);
        idle();
        compares++;
        if (dut_res() !== exp_res || bus.out_valid !== 1'b1 || bus.hit !== 1'b0) begin
            fails++;
            $display("FAIL shadow_not_active: got %s want %s", fmt(dut_res()), fmt(exp_res));
        end
        frame();
        pixel(205, 205);
        idle();
        compares++;
        if (dut_res() !== exp_res || bus.hit !== 1'b1 || bus.hit_idx !== 2'd0) begin
            fails++;
            $display("FAIL shadow_after_frame: got %s want %s", fmt(dut_res()), fmt(exp_res));
        end
        step(0, 0, 0, 1, 1, 0, 300, 300);
        pixel(305, 305);
        idle();
        compares++;
        if (dut_res() !== exp_res || bus.hit !== 1'b1 || bus.hit_idx !== 2'd0 ||
            bus.obj_x !== 5'd5 || bus.obj_y !== 5'd5) begin
            fails++;
            $display("FAIL write_through: got %s want %s", fmt(dut_res()), fmt(exp_res));
        end
    endtask

    task automatic rand_cycle();
        int o;
        int px;
        int py;
        bit pv;
        bit fs;
        bit we;
        int wi;
        int wx;
        int wy;
        int sel;
        o  = int'($urandom_range(0, NUM_OBJ - 1));
        pv = ($urandom_range(0, 3) != 0);
        px = m_ax[o] + int'($urandom_range(0, 40)) - 4;
        py = m_ay[o] + int'($urandom_range(0, 40)) - 4;
        fs = ($urandom_range(0, 15) == 0);
        we = ($urandom_range(0, 3) == 0);
        wi = int'($urandom_range(0, NUM_OBJ - 1));
        sel = int'($urandom_range(0, 3));
        if (sel < 2) begin
            wx = int'($urandom_range(0, 96));
            wy = int'($urandom_range(0, 96));
        end else if (sel == 2) begin
            wx = int'($urandom_range(0, CMASK));
            wy = int'($urandom_range(0, CMASK));
        end else begin
            wx = int'($urandom_range(990, CMASK));
            wy = int'($urandom_range(990, CMASK));
        end
        step(pv, px, py, fs, we, wi, wx, wy);
    endtask

    task automatic test_random(input int cycles);
        for (int c = 0; c < cycles; c++) begin
            rand_cycle();
            compares++;
            if (dut_res() !== exp_res) begin
                fails++;
                $display("FAIL random_cycle_%0d: got %s want %s", c, fmt(dut_res()), fmt(exp_res));
            end
        end
    endtask

    task automatic test_reset_mid_stream();
        for (int c = 0; c < 8; c++) begin
            step(c[0], 20 + c, 20 + c, 0, 0, 0, 0, 0);
        end
        @(negedge clk) rst_n = 1'b0;
        #1;
        model_reset();
        compares++;
        if (dut_res() !== res_t'(0)) begin
            fails++;
            $display("FAIL mid_reset_immediate: got %s want all zero", fmt(dut_res()));
        end
        bus.pix_valid = 1'b1;
        @(posedge clk);
        #1;
        compares++;
        if (dut_res() !== res_t'(0)) begin
            fails++;
            $display("FAIL mid_reset_held: got %s want all zero", fmt(dut_res()));
        end
        @(negedge clk) rst_n = 1'b1;
        idle();
        idle();
        compares++;
        if (dut_res() !== exp_res || bus.out_valid !== 1'b0) begin
            fails++;
            $display("FAIL restart_no_stale: got %s want %s", fmt(dut_res()), fmt(exp_res));
        end
        pixel(3, 3);
        compares++;
        if (bus.out_valid !== 1'b0) begin
            fails++;
            $display("FAIL restart_latency_early: got out_valid=%0b want 0", bus.out_valid);
        end
        idle();
        compares++;
        if (dut_res() !== exp_res || bus.out_valid !== 1'b1 || bus.hit_mask !== 4'b1111) begin
            fails++;
            $display("FAIL restart_latency_two: got %s want %s", fmt(dut_res()), fmt(exp_res));
        end
    endtask

    initial begin
        rst_n           = 1'b1;
        bus.pix_valid   = 1'b0;
        bus.pix_x       = '0;
        bus.pix_y       = '0;
        bus.frame_start = 1'b0;
        bus.pos_wr_en   = 1'b0;
        bus.pos_wr_idx  = '0;
        bus.pos_wr_x    = '0;
        bus.pos_wr_y    = '0;
        model_reset();

        test_reset();
        test_hit_offsets();
        test_overlap();
        test_screen_edge();
        test_shadow();
        test_random(400);
        test_reset_mid_stream();
        test_random(200);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
        $finish;
    end

endmodule
